// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and queue-entry type for the instruction fetch queue
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    // One decoded-side queue slot: the instruction word and the address it came from.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO with synchronous flush, used as the fetched-instruction queue
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign rd_en    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue can still take a push.
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC, request throttling, redirect drop accounting; optional FETCH_QUEUE_MISALIGN_EN
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
`ifdef FETCH_QUEUE_MISALIGN_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   head_pc_q, head_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW:0]       occupancy;
    logic [XLEN-1:0]   redirect_target;
    logic              halted;
    logic              req_fire;
    logic              rsp_keep;
    logic              fifo_pop;
    logic [2*XLEN-1:0] fifo_head;

`ifdef FETCH_QUEUE_MISALIGN_EN
    logic misalign_q;
    assign redirect_target = redirect_pc;
    assign halted          = misalign_q;
    assign misalign        = misalign_q;

    // Sticky misalign flag: set by an unaligned redirect, cleared by an aligned one.
    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end
`else
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign halted          = 1'b0;
`endif

    // Queued plus outstanding entries bound the requests so responses always fit.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req_valid = !reset && !stall && !redirect_valid && !halted
                            && !fifo_full && (occupancy < DEPTH_V);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign out_valid      = !fifo_empty;
    assign fifo_pop       = out_valid && out_ready && !redirect_valid;
    assign out_pc         = fifo_head[2*XLEN-1:XLEN];
    assign out_instr      = fifo_head[XLEN-1:0];

    // Next-state for PC, the PC of the next kept response, in-flight and drop counters.
    always_comb begin
        pc_d       = pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding belongs to the old path and must be dropped.
            pc_d       = redirect_target;
            head_pc_d  = redirect_target;
            inflight_d = inflight_q - CW'(imem_rsp_valid);
            drop_d     = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            case ({req_fire, imem_rsp_valid})
                2'b10:   inflight_d = inflight_q + CW'(1);
                2'b01:   inflight_d = inflight_q - CW'(1);
                default: inflight_d = inflight_q;
            endcase
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                head_pc_d = head_pc_q + XLEN'(4);
            end
        end
    end

    // Fetch state registers; reset abandons all outstanding requests.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            head_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH(2*XLEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({head_pc_q, imem_rsp_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, PC loaded on reset.
REQ-004 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output XLEN: fetch request handshake.
REQ-007 SHALL have ports imem_rsp_valid input 1, imem_rsp_data input XLEN: in-order instruction return, no backpressure.
REQ-008 SHALL have ports redirect_valid input 1, redirect_pc input XLEN: jal/jalr/branch target from execute.
REQ-009 SHALL have port stall input 1: suppresses new fetch requests.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_pc output XLEN, out_instr output XLEN: decode handshake.
REQ-011 SHALL have port misalign output 1 (present only with FETCH_QUEUE_MISALIGN_EN).

Function
REQ-012 SHALL hold fetch PC register; request accepted when imem_req_valid && imem_req_ready; accepted request advances PC by 4 (mod 2^XLEN wrap).
REQ-013 SHALL assert imem_req_valid only when !stall, !redirect_valid, and (queued + in-flight) < DEPTH; imem_req_addr = fetch PC.
REQ-014 SHALL track in-flight count (0..DEPTH); +1 on accept, -1 on imem_rsp_valid; simultaneous accept and response leaves count unchanged.
REQ-015 SHALL write each non-discarded response into queue tail with its request PC (per-entry PC FIFO or in-flight PC FIFO).
REQ-016 SHALL present queue head on out_*; out_valid = queue non-empty; pop on out_valid && out_ready; zero bypass latency (response visible on out_* earliest next cycle).
REQ-017 SHALL support simultaneous push and pop when full or empty without loss; queue never overflows by construction of REQ-013.
REQ-018 On redirect_valid: flush queue (out_valid low next cycle), PC <= redirect_pc, drop counter <= current in-flight count minus any response arriving this cycle; no request issued that cycle.
REQ-019 SHALL discard responses while drop counter > 0, decrementing per response; discarded responses never reach out_*.
REQ-020 Redirect has priority over stall, pop, push and request; redirect during stall still updates PC.
REQ-021 Redirect while drop counter nonzero SHALL set drop counter to total outstanding (old drops + live in-flight).
REQ-022 stall SHALL not block out_* draining nor response acceptance.

Reset
REQ-023 On reset: PC = RESET_PC, queue empty, in-flight = 0, drop counter = 0, out_valid = 0, imem_req_valid = 0, misalign = 0.
REQ-024 Reset mid-operation SHALL abandon in-flight requests; memory subsystem is reset concurrently, so no drop accounting carries over.
REQ-025 First request SHALL issue in the cycle after reset deasserts, addr RESET_PC.

Configuration
REQ-026 Macro FETCH_QUEUE_MISALIGN_EN: when defined, redirect_pc[1:0] != 0 sets sticky misalign, PC loaded, fetch halts (imem_req_valid low) until reset or an aligned redirect, which clears misalign.
REQ-027 Without FETCH_QUEUE_MISALIGN_EN: no misalign port; redirect_pc[1:0] forced to 0 on load.

Structure
REQ-028 Shared package fetch_pkg SHALL hold XLEN default, RESET_PC default, and the queue-entry struct {pc, instr}.
REQ-029 Queue SHALL be a sub-module fetch_fifo (parametrised width/depth, push/pop/full/empty/count, synchronous flush).
REQ-030 Top SHALL contain PC, in-flight and drop counters, request logic.

Verification
REQ-031 Reset then imem_req_ready=1, rsp 1 cycle later, out_ready=1 -> out_pc sequence 0,4,8,C; instrs match.
REQ-032 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid then low; out_ready=1 -> resumes, no loss.
REQ-033 Two requests in flight, redirect_pc=0x100 -> both responses discarded, next out_pc=0x100.
REQ-034 stall=1 for 5 cycles with queue data -> no requests, queue drains; redirect_pc=0x40 during stall -> first request after stall addr 0x40.
REQ-035 PC=0xFFFFFFFC -> next request addr 0x0 (wrap).
REQ-036 With macro: redirect_pc=0x102 -> misalign=1, no requests; redirect_pc=0x200 -> misalign=0, fetch 0x200.
